// File: rtl/serial_frame_deserializer.sv
// Serial frame deserializer: collects a 1..WIDTH bit serial frame (MSB- or
// LSB-first), presents it right-justified in a held output register and keeps it
// under a Valid/Ack handshake while the next frame is already being received.
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no frame in progress; waiting for Enable&Start
// SHIFT | frame in progress; collecting bits 2..N on Enable strobes
module serial_frame_deserializer #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_enable,
  input  logic             i_start,
  input  logic             i_serial,
  input  logic [CNT_W-1:0] i_frame_size,
  input  logic             i_msb_first,
  input  logic             i_ack,
  output logic [WIDTH-1:0] o_parallel,
  output logic             o_valid,
  output logic             o_busy,
  output logic             o_overrun
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] L_WIDTH = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] L_ONE   = CNT_W'(1);

  state_t           r_state;
  logic [WIDTH-1:0] r_shift;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_n;
  logic             r_msb;
  logic [WIDTH-1:0] r_parallel;
  logic             r_valid;
  logic             r_overrun;

  logic [CNT_W-1:0] w_size_n;
  logic             w_restart;
  logic             w_advance;
  logic [WIDTH-1:0] w_bit_word;
  logic [WIDTH-1:0] w_shift_next;
  logic [CNT_W-1:0] w_cnt_next;
  logic [CNT_W-1:0] w_n_eff;
  logic             w_done;

  // Next-bit datapath: out-of-range sizes fold to WIDTH; a Start always restarts.
  always_comb begin
    w_size_n     = ((i_frame_size == '0) || (i_frame_size > L_WIDTH)) ? L_WIDTH : i_frame_size;
    w_restart    = i_enable & i_start;
    w_advance    = i_enable & ~i_start & (r_state == SHIFT);
    w_bit_word   = {{(WIDTH-1){1'b0}}, i_serial};
    w_shift_next = r_shift;
    w_cnt_next   = r_cnt;
    w_n_eff      = r_n;
    if (w_restart) begin
      // First bit lands in [0] for both orders; upper bits start cleared.
      w_shift_next = w_bit_word;
      w_cnt_next   = L_ONE;
      w_n_eff      = w_size_n;
    end else if (w_advance) begin
      if (r_msb) begin
        w_shift_next = {r_shift[WIDTH-2:0], i_serial};
      end else begin
        w_shift_next = r_shift | (w_bit_word << r_cnt);
      end
      w_cnt_next = r_cnt + L_ONE;
    end
    w_done = (w_restart | w_advance) & (w_cnt_next == w_n_eff);
  end

  // Frame FSM and shift register.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
      r_n     <= '0;
      r_msb   <= 1'b0;
    end else if (w_restart) begin
      r_shift <= w_shift_next;
      r_cnt   <= w_cnt_next;
      r_n     <= w_size_n;
      r_msb   <= i_msb_first;
      r_state <= w_done ? IDLE : SHIFT;
    end else if (w_advance) begin
      r_shift <= w_shift_next;
      r_cnt   <= w_cnt_next;
      r_state <= w_done ? IDLE : SHIFT;
    end
  end

  // Output word register with Valid/Ack handshake and sticky overrun.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_parallel <= '0;
      r_valid    <= 1'b0;
      r_overrun  <= 1'b0;
    end else if (w_done) begin
      r_parallel <= w_shift_next;
      r_valid    <= 1'b1;
      if (r_valid && !i_ack) begin
        r_overrun <= 1'b1;
      end
    end else if (i_ack) begin
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end
  end

  assign o_parallel = r_parallel;
  assign o_valid    = r_valid;
  assign o_overrun  = r_overrun;
  assign o_busy     = (r_state == SHIFT);

endmodule
